// File: rtl/ir_exec_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ir_exec_unit: GPR execution unit (movsgpr/mov/add/sub, shift-add mul). Rev 1.0
// ---------------------------------------------------------------------------
module ir_exec_unit #(
  parameter int DW   = 16,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  output logic          instr_ready,
  output logic          done,
  output logic          illegal,
  output logic [3:0]    flags,
  output logic [DW-1:0] sgpr,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);
  localparam int              AW         = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0]      NREG_W     = 6'(NREG);
  localparam logic [DW-1:0]   LAST_STEP  = DW'(DW - 1);
  localparam logic [4:0]      OP_MOVSGPR = 5'd0;
  localparam logic [4:0]      OP_MOV     = 5'd1;
  localparam logic [4:0]      OP_ADD     = 5'd2;
  localparam logic [4:0]      OP_SUB     = 5'd3;
  localparam logic [4:0]      OP_MUL     = 5'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, WB = 2'd3} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] gpr [NREG];

  logic [4:0]    dec_op, dec_rdst, dec_rs1, dec_rs2;
  logic          dec_imm, dec_legal;
  logic [DW-1:0] dec_a, dec_b;

  logic [4:0]      op_q;
  logic [AW-1:0]   rdst_q;
  logic            imm_q, legal_q;
  logic [DW-1:0]   a_q, b_q;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   cnt;

  assign dec_op   = instr[31:27];
  assign dec_rdst = instr[26:22];
  assign dec_rs1  = instr[21:17];
  assign dec_imm  = instr[16];
  assign dec_rs2  = instr[15:11];

  // Out-of-range source indices read as zero
  assign dec_a = ({1'b0, dec_rs1} < NREG_W) ? gpr[dec_rs1[AW-1:0]] : '0;
  assign dec_b = dec_imm ? DW'(instr[15:0])
               : (({1'b0, dec_rs2} < NREG_W) ? gpr[dec_rs2[AW-1:0]] : '0);
  assign dec_legal = (dec_op <= OP_MUL) && ({1'b0, dec_rdst} < NREG_W);

  assign dbg_data = ({1'b0, dbg_addr} < NREG_W) ? gpr[dbg_addr[AW-1:0]] : '0;

  logic [DW:0]   add_w, sub_w, step_sum;
  logic [DW-1:0] alu_res, prod_hi, prod_lo;
  logic          alu_c, alu_v;

  assign add_w    = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w    = {1'b0, a_q} - {1'b0, b_q};
  assign prod_hi  = prod[2*DW-1:DW];
  assign prod_lo  = prod[DW-1:0];
  // Multiplier bits sit in the low half and shift out as the partial sum shifts in
  assign step_sum = {1'b0, prod_hi} + (prod[0] ? {1'b0, a_q} : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_MOVSGPR: alu_res = sgpr;
      OP_MOV:     alu_res = imm_q ? b_q : a_q;
      OP_ADD: begin
        alu_res = add_w[DW-1:0];
        alu_c   = add_w[DW];
        alu_v   = (a_q[DW-1] == b_q[DW-1]) && (add_w[DW-1] != a_q[DW-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[DW-1:0];
        alu_c   = sub_w[DW];
        alu_v   = (a_q[DW-1] != b_q[DW-1]) && (sub_w[DW-1] != a_q[DW-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nxt = (dec_legal && (dec_op == OP_MUL)) ? MUL : EXEC;
      end
      EXEC:    state_nxt = IDLE;
      MUL:     if (cnt == LAST_STEP) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      sgpr    <= '0;
      flags   <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      op_q    <= '0;
      rdst_q  <= '0;
      imm_q   <= 1'b0;
      legal_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod    <= '0;
      cnt     <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          op_q    <= dec_op;
          rdst_q  <= dec_rdst[AW-1:0];
          imm_q   <= dec_imm;
          legal_q <= dec_legal;
          a_q     <= dec_a;
          b_q     <= dec_b;
          prod    <= {{DW{1'b0}}, dec_b};
          cnt     <= '0;
        end
        EXEC: begin
          if (legal_q) begin
            gpr[rdst_q] <= alu_res;
            flags       <= {alu_res == '0, alu_res[DW-1], alu_c, alu_v};
            done        <= 1'b1;
          end else begin
            illegal <= 1'b1;
          end
        end
        MUL: begin
          prod <= {step_sum, prod[DW-1:1]};
          cnt  <= cnt + DW'(1);
        end
        WB: begin
          gpr[rdst_q] <= prod_lo;
          sgpr        <= prod_hi;
          flags       <= {prod_lo == '0, prod_lo[DW-1], prod_hi != '0, 1'b0};
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_exec_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ir_exec_unit: scoreboard bench with arithmetic reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_ir_exec_unit;
  localparam int DW   = 16;
  localparam int NREG = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic          instr_ready, done, illegal;
  logic [3:0]    flags;
  logic [DW-1:0] sgpr;
  logic [4:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  ir_exec_unit #(.DW(DW), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .done(done), .illegal(illegal), .flags(flags),
    .sgpr(sgpr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               is_ill;
    logic [3:0]       fl;
    logic [15:0]      sg;
    logic [31:0][15:0] regs;
    int               acc;
    int               lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_gpr [NREG];
  logic [15:0] m_sgpr;
  logic [3:0]  m_flags;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_gpr[i] = '0;
    m_sgpr  = '0;
    m_flags = '0;
  endtask

  task automatic model_exec(input logic [31:0] ins, output exp_t e);
    int unsigned op, rd, s1, s2, a, b, res, full;
    int sa, sb, sr;
    bit c, v, imm;
    op = ins[31:27]; rd = ins[26:22]; s1 = ins[21:17]; imm = ins[16]; s2 = ins[15:11];
    a  = (s1 < NREG) ? m_gpr[s1] : 0;
    b  = imm ? ins[15:0] : ((s2 < NREG) ? m_gpr[s2] : 0);
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    c = 0; v = 0; res = 0;
    e.is_ill = (op > 4) || (rd >= NREG);
    e.lat = 1;
    if (!e.is_ill) begin
      case (op)
        0: res = m_sgpr;
        1: res = imm ? b : a;
        2: begin full = a + b; res = full % 65536; c = (full > 65535);
                 sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
        3: begin res = (a + 65536 - b) % 65536; c = (a < b);
                 sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
        default: begin full = a * b; res = full % 65536; m_sgpr = 16'(full / 65536);
                 c = (m_sgpr != 0); e.lat = DW + 1; end
      endcase
      m_gpr[rd] = 16'(res);
      m_flags   = {res == 0, res >= 32768, c, v};
    end
    e.fl   = m_flags;
    e.sg   = m_sgpr;
    e.regs = '0;
    for (int i = 0; i < NREG; i++) e.regs[i] = m_gpr[i];
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] s1, input logic im, input logic [15:0] lo);
    return {op, rd, s1, im, lo};
  endfunction

  function automatic logic [15:0] rs2(input logic [4:0] r);
    return {r, 11'h000};
  endfunction

  task automatic issue(input logic [31:0] ins);
    exp_t e;
    int k = 0;
    @(negedge clk);
    while (!instr_ready && k < 100) begin @(negedge clk); k++; end
    if (!instr_ready) begin
      check("ready_timeout", 32'(instr_ready), 32'd1);
      return;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    model_exec(ins, e);
    e.acc = cyc;
    exp_q.push_back(e);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk); #45; k++; end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Monitor: pops one expectation per done/illegal pulse
  initial begin
    exp_t e;
    int   bad_reg;
    forever begin
      @(negedge clk);
      if (rst_n && (done || illegal)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, done, illegal}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done", 32'(done), 32'(!e.is_ill));
          check("illegal", 32'(illegal), 32'(e.is_ill));
          check("flags", 32'(flags), 32'(e.fl));
          check("sgpr", 32'(sgpr), 32'(e.sg));
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          bad_reg = -1;
          for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            if (dbg_data !== e.regs[i] && bad_reg < 0) bad_reg = i;
          end
          check("gpr_first_bad_index", 32'(bad_reg), 32'hFFFF_FFFF);
        end
      end
    end
  end

  initial begin
    logic [4:0]  op, rd, s1;
    logic        im;
    logic [15:0] lo;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_sgpr", 32'(sgpr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(mk(5'd1, 5'd1, 5'd0, 1'b1, 16'h0005));
    issue(mk(5'd2, 5'd2, 5'd1, 1'b1, 16'hFFFF));
    drain();
    check("add_wrap_flags", 32'(flags), 32'h2);

    issue(mk(5'd3, 5'd3, 5'd1, 1'b0, rs2(5'd1)));
    drain();
    check("sub_self_flags", 32'(flags), 32'h8);
    issue(mk(5'd3, 5'd4, 5'd0, 1'b1, 16'h0001));
    drain();
    check("sub_borrow_flags", 32'(flags), 32'h6);

    issue(mk(5'd1, 5'd7, 5'd0, 1'b1, 16'h1234));
    issue(mk(5'd1, 5'd8, 5'd0, 1'b1, 16'h5678));
    issue(mk(5'd4, 5'd5, 5'd7, 1'b0, rs2(5'd8)));
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("ready_low_in_mul", 32'(instr_ready), 32'd0);
      if (i < 16) begin instr_valid = 1'b1; instr = $urandom; end
      else instr_valid = 1'b0;
    end
    drain();
    check("mul_sgpr", 32'(sgpr), 32'h0626);
    check("mul_flags", 32'(flags), 32'h2);
    issue(mk(5'd0, 5'd6, 5'd0, 1'b0, 16'h0000));
    drain();
    check("movsgpr_flags", 32'(flags), 32'h0);

    issue(mk(5'd1, 5'd9, 5'd0, 1'b1, 16'h7FFF));
    issue(mk(5'd2, 5'd10, 5'd9, 1'b1, 16'h0001));
    drain();
    check("add_ovf_flags", 32'(flags), 32'h5);

    issue(mk(5'd7, 5'd3, 5'd1, 1'b1, 16'h0005));
    issue(mk(5'd1, 5'd20, 5'd0, 1'b1, 16'hABCD));
    drain();
    check("illegal_keeps_flags", 32'(flags), 32'h5);

    // Abort a multiply after its fifth step
    issue(mk(5'd4, 5'd11, 5'd7, 1'b0, rs2(5'd8)));
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_sgpr", 32'(sgpr), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(5'd2, 5'd1, 5'd0, 1'b1, 16'h0003));
    drain();

    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) < 9) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(5, 31));
      rd = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      s1 = 5'($urandom_range(0, 17));
      im = 1'($urandom_range(0, 1));
      lo = 16'($urandom);
      if (!im) lo[15:11] = 5'($urandom_range(0, 17));
      issue(mk(op, rd, s1, im, lo));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
